// File: rtl/apu_pkg.sv
// Shared APU constants: length-field widths and channel indices.
package apu_pkg;

   localparam int unsigned LEN_W_SQ   = 6;
   localparam int unsigned LEN_W_WAVE = 8;
   localparam int unsigned NUM_APU_CH = 4;

   localparam int unsigned CH_SQ1   = 0;
   localparam int unsigned CH_SQ2   = 1;
   localparam int unsigned CH_WAVE  = 2;
   localparam int unsigned CH_NOISE = 3;

endpackage : apu_pkg

// File: rtl/length_counter_ch.sv
// Single-channel APU length timer: counter, channel-enable flag and the
// trigger/enable-edge quirks of the original hardware.
module length_counter_ch #(
   parameter int unsigned LEN_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             lengthTick,
   input  logic             seqPhaseOdd,
   input  logic [LEN_W-1:0] lengthLoad,
   input  logic             writeLen,
   input  logic             trigger,
   input  logic             lengthEnable,
   input  logic             dacEn,
   output logic             chanEnable,
   output logic             counterZero
);

   localparam int unsigned CNT_W = LEN_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {1'b1, {LEN_W{1'b0}}};

   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] decCount;
   logic [CNT_W-1:0] counterNxt;
   logic             lenEnQ;
   logic             clkLen;
   logic             hitZero;
   logic             chanEnNxt;

   // Next counter and enable: load beats decrement, decrement beats trigger reload.
   always_comb begin
      decCount   = counter;
      hitZero    = 1'b0;
      counterNxt = counter;
      chanEnNxt  = chanEnable;

      // A rising length_enable in the odd phase steals an extra clock; it
      // merges with a coincident tick into a single decrement.
      clkLen = (lengthTick & lengthEnable) | (lengthEnable & ~lenEnQ & seqPhaseOdd);

      if (clkLen && (counter != '0)) begin
         decCount = counter - CNT_W'(1);
         hitZero  = (decCount == '0);
      end

      if (writeLen) begin
         counterNxt = CNT_MAX - {1'b0, lengthLoad};
      end else if (trigger && (decCount == '0)) begin
         counterNxt = (lengthEnable && seqPhaseOdd) ? (CNT_MAX - CNT_W'(1)) : CNT_MAX;
      end else begin
         counterNxt = decCount;
      end

      // DAC power dominates; trigger re-arms; expiry silences the channel.
      if (!dacEn) begin
         chanEnNxt = 1'b0;
      end else if (trigger) begin
         chanEnNxt = 1'b1;
      end else if (hitZero && !writeLen) begin
         chanEnNxt = 1'b0;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter     <= '0;
         chanEnable  <= 1'b0;
         lenEnQ      <= 1'b0;
         counterZero <= 1'b1;
      end else begin
         counter     <= counterNxt;
         chanEnable  <= chanEnNxt;
         lenEnQ      <= lengthEnable;
         counterZero <= (counterNxt == '0);
      end
   end

endmodule : length_counter_ch

// File: rtl/length_counter_multi.sv
// Bank of independent APU length timers, one per channel, sliced from flat
// register-file buses. The wave channel uses its own instance with LEN_W=8.
module length_counter_multi
   import apu_pkg::*;
#(
   parameter int unsigned NUM_CH = NUM_APU_CH,
   parameter int unsigned LEN_W  = LEN_W_SQ
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    length_tick,
   input  logic                    seq_phase_odd,
   input  logic [NUM_CH*LEN_W-1:0] length_load,
   input  logic [NUM_CH-1:0]       write_len,
   input  logic [NUM_CH-1:0]       trigger,
   input  logic [NUM_CH-1:0]       length_enable,
   input  logic [NUM_CH-1:0]       dac_en,
   output logic [NUM_CH-1:0]       chan_enable,
   output logic [NUM_CH-1:0]       counter_zero
);

   // One length timer per channel.
   for (genvar c = 0; c < NUM_CH; c++) begin : gCh
      length_counter_ch #(
         .LEN_W (LEN_W)
      ) uCh (
         .clk          (clk),
         .rst_n        (rst_n),
         .lengthTick   (length_tick),
         .seqPhaseOdd  (seq_phase_odd),
         .lengthLoad   (length_load[c*LEN_W +: LEN_W]),
         .writeLen     (write_len[c]),
         .trigger      (trigger[c]),
         .lengthEnable (length_enable[c]),
         .dacEn        (dac_en[c]),
         .chanEnable   (chan_enable[c]),
         .counterZero  (counter_zero[c])
      );
   end

endmodule : length_counter_multi

// File: tb/tb_length_counter_multi.sv
// Bench for length_counter_multi: a 4-channel 6-bit bank plus a 1-channel
// 8-bit (wave) bank, checked every cycle against a behavioural model.
module tb_length_counter_multi;
   import apu_pkg::*;

   localparam int unsigned NCH = NUM_APU_CH;
   localparam int unsigned W6  = LEN_W_SQ;
   localparam int unsigned W8  = LEN_W_WAVE;
   localparam int          NM  = 5;   // model slots 0..3 = 6-bit bank, 4 = wave

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              lengthTick = 1'b0;
   logic              seqPhaseOdd = 1'b0;
   logic [NCH*W6-1:0] lengthLoad6 = '0;
   logic [NCH-1:0]    writeLen = '0;
   logic [NCH-1:0]    trigger = '0;
   logic [NCH-1:0]    lengthEnable = '0;
   logic [NCH-1:0]    dacEn = '0;
   logic [NCH-1:0]    chanEnable6;
   logic [NCH-1:0]    counterZero6;
   logic [W8-1:0]     lengthLoad8 = '0;
   logic [0:0]        writeLen8 = '0;
   logic [0:0]        trigger8 = '0;
   logic [0:0]        lengthEnable8 = '0;
   logic [0:0]        dacEn8 = '0;
   logic [0:0]        chanEnable8;
   logic [0:0]        counterZero8;

   int testsRun = 0;
   int testsFailed = 0;

   int mCnt [NM];
   int mEn  [NM];
   int mLeQ [NM];

   length_counter_multi #(.NUM_CH(NCH), .LEN_W(W6)) dut6 (
      .clk (clk), .rst_n (rst_n), .length_tick (lengthTick), .seq_phase_odd (seqPhaseOdd),
      .length_load (lengthLoad6), .write_len (writeLen), .trigger (trigger),
      .length_enable (lengthEnable), .dac_en (dacEn),
      .chan_enable (chanEnable6), .counter_zero (counterZero6)
   );

   length_counter_multi #(.NUM_CH(1), .LEN_W(W8)) dut8 (
      .clk (clk), .rst_n (rst_n), .length_tick (lengthTick), .seq_phase_odd (seqPhaseOdd),
      .length_load (lengthLoad8), .write_len (writeLen8), .trigger (trigger8),
      .length_enable (lengthEnable8), .dac_en (dacEn8),
      .chan_enable (chanEnable8), .counter_zero (counterZero8)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic checkEq(input string tag, input int act, input int exp);
      testsRun++;
      if (act != exp) begin
         testsFailed++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int zeroOf(input int ch);
      return (ch == 4) ? 32'(counterZero8[0]) : 32'(counterZero6[ch]);
   endfunction

   function automatic int enOf(input int ch);
      return (ch == 4) ? 32'(chanEnable8[0]) : 32'(chanEnable6[ch]);
   endfunction

   task automatic modelReset();
      for (int ch = 0; ch < NM; ch++) begin
         mCnt[ch] = 0; mEn[ch] = 0; mLeQ[ch] = 0;
      end
   endtask

   // Behavioural rules of one length timer applied to every model slot.
   task automatic modelStep();
      for (int ch = 0; ch < NM; ch++) begin
         int  w, mx, ld, dec, nc;
         bit  le, wl, tr, de, clkL, expired;
         if (ch == 4) begin
            w = W8; ld = int'(lengthLoad8);
            le = lengthEnable8[0]; wl = writeLen8[0]; tr = trigger8[0]; de = dacEn8[0];
         end else begin
            w = W6; ld = int'(lengthLoad6[ch*W6 +: W6]);
            le = lengthEnable[ch]; wl = writeLen[ch]; tr = trigger[ch]; de = dacEn[ch];
         end
         mx = 1 << w;
         clkL = le && (lengthTick || (mLeQ[ch] == 0 && seqPhaseOdd));
         dec = mCnt[ch];
         expired = 1'b0;
         if (clkL && mCnt[ch] > 0) begin
            dec = mCnt[ch] - 1;
            expired = (dec == 0);
         end
         if (wl)                 nc = mx - ld;
         else if (tr && dec == 0) nc = (le && seqPhaseOdd) ? mx - 1 : mx;
         else                    nc = dec;
         if (!de)                       mEn[ch] = 0;
         else if (tr)                   mEn[ch] = 1;
         else if (expired && !wl)       mEn[ch] = 0;
         mCnt[ch] = nc;
         mLeQ[ch] = int'(le);
      end
   endtask

   task automatic checkAll();
      for (int ch = 0; ch < NM; ch++) begin
         checkEq($sformatf("chan_enable[%0d]", ch), enOf(ch), mEn[ch]);
         checkEq($sformatf("counter_zero[%0d]", ch), zeroOf(ch), (mCnt[ch] == 0) ? 1 : 0);
      end
   endtask

   // One clock: model updates on the edge, outputs compared on the falling edge,
   // then the one-cycle strobes are released.
   task automatic stepCycle();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkAll();
      lengthTick = 1'b0;
      writeLen = '0;
      trigger = '0;
      writeLen8 = '0;
      trigger8 = '0;
   endtask

   task automatic load6(input int ch, input int v, input bit trig);
      lengthLoad6[ch*W6 +: W6] = W6'(v);
      writeLen[ch] = 1'b1;
      trigger[ch] = trig;
      stepCycle();
   endtask

   // Ticks until counter_zero rises; reveals the counter value indirectly.
   task automatic ticksToZero(input int ch, input int exp, input string tag);
      int n;
      n = -1;
      seqPhaseOdd = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         lengthTick = 1'b1;
         stepCycle();
         if (zeroOf(ch) != 0) begin
            n = i;
            break;
         end
      end
      checkEq(tag, n, exp);
   endtask

   initial begin
      modelReset();
      // Reset state
      #12;
      checkEq("rst counter_zero6", 32'(counterZero6), 15);
      checkEq("rst chan_enable6", 32'(chanEnable6), 0);
      checkEq("rst counter_zero8", 32'(counterZero8), 1);
      checkEq("rst chan_enable8", 32'(chanEnable8), 0);
      @(negedge clk);
      rst_n = 1'b1;
      dacEn = '1;
      dacEn8 = 1'b1;

      // Load 61 with trigger, then three ticks drain it
      lengthEnable[CH_SQ1] = 1'b1;
      load6(CH_SQ1, 61, 1'b1);
      checkEq("load en", enOf(CH_SQ1), 1);
      for (int i = 0; i < 3; i++) begin
         lengthTick = 1'b1;
         stepCycle();
         checkEq($sformatf("drain en %0d", i), enOf(CH_SQ1), (i < 2) ? 1 : 0);
         checkEq($sformatf("drain zero %0d", i), zeroOf(CH_SQ1), (i < 2) ? 0 : 1);
      end

      // Trigger at zero: full reload, or one less in the odd phase
      seqPhaseOdd = 1'b0;
      trigger[CH_SQ1] = 1'b1;
      stepCycle();
      checkEq("trig0 en", enOf(CH_SQ1), 1);
      ticksToZero(CH_SQ1, 64, "trig even reload");
      seqPhaseOdd = 1'b1;
      trigger[CH_SQ1] = 1'b1;
      stepCycle();
      ticksToZero(CH_SQ1, 63, "trig odd reload");

      // Extra clock on length_enable rising edge
      lengthEnable[CH_SQ2] = 1'b0;
      load6(CH_SQ2, 59, 1'b1);
      seqPhaseOdd = 1'b1; lengthEnable[CH_SQ2] = 1'b1;
      stepCycle();
      ticksToZero(CH_SQ2, 4, "extra clk odd");
      lengthEnable[CH_SQ2] = 1'b0;
      load6(CH_SQ2, 59, 1'b0);
      seqPhaseOdd = 1'b0; lengthEnable[CH_SQ2] = 1'b1;
      stepCycle();
      ticksToZero(CH_SQ2, 5, "no extra clk even");
      lengthEnable[CH_SQ2] = 1'b0;
      load6(CH_SQ2, 59, 1'b0);
      seqPhaseOdd = 1'b1; lengthEnable[CH_SQ2] = 1'b1; lengthTick = 1'b1;
      stepCycle();
      ticksToZero(CH_SQ2, 4, "extra clk with tick");

      // DAC kill and frozen counter
      dacEn[CH_WAVE] = 1'b0;
      trigger[CH_WAVE] = 1'b1;
      stepCycle();
      checkEq("dac kill", enOf(CH_WAVE), 0);
      dacEn[CH_WAVE] = 1'b1;
      lengthEnable[CH_NOISE] = 1'b0;
      load6(CH_NOISE, 54, 1'b1);
      for (int i = 0; i < 10; i++) begin
         lengthTick = 1'b1;
         stepCycle();
      end
      checkEq("frozen zero", zeroOf(CH_NOISE), 0);
      checkEq("frozen en", enOf(CH_NOISE), 1);
      seqPhaseOdd = 1'b0; lengthEnable[CH_NOISE] = 1'b1;
      stepCycle();
      ticksToZero(CH_NOISE, 10, "frozen count kept");

      // 8-bit instance: load 0 means 256, no wrap afterwards
      seqPhaseOdd = 1'b0;
      lengthEnable8 = 1'b1;
      lengthLoad8 = '0; writeLen8 = 1'b1; trigger8 = 1'b1;
      stepCycle();
      for (int i = 0; i < 257; i++) begin
         lengthTick = 1'b1;
         stepCycle();
         if (i == 254) checkEq("w8 en before last", enOf(4), 1);
      end
      checkEq("w8 en after", enOf(4), 0);
      checkEq("w8 no wrap", zeroOf(4), 1);

      // Async reset in the middle of a count
      load6(CH_SQ1, 47, 1'b1);
      checkEq("pre-reset en", enOf(CH_SQ1), 1);
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkEq("async rst en", 32'(chanEnable6), 0);
      checkEq("async rst zero", 32'(counterZero6), 15);
      checkEq("async rst zero8", 32'(counterZero8), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic on both banks
      for (int n = 0; n < 3000; n++) begin
         lengthTick  = ($urandom_range(0, 7) == 0);
         seqPhaseOdd = $urandom_range(0, 1) == 1;
         for (int ch = 0; ch < int'(NCH); ch++) begin
            lengthLoad6[ch*W6 +: W6] = W6'($urandom);
            writeLen[ch] = ($urandom_range(0, 15) == 0);
            trigger[ch]  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) lengthEnable[ch] = ~lengthEnable[ch];
            dacEn[ch] = ($urandom_range(0, 15) != 0);
         end
         lengthLoad8 = W8'($urandom);
         writeLen8[0] = ($urandom_range(0, 31) == 0);
         trigger8[0]  = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 63) == 0) lengthEnable8[0] = ~lengthEnable8[0];
         dacEn8[0] = ($urandom_range(0, 31) != 0);
         stepCycle();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule : tb_length_counter_multi

// File: doc/length_counter_multi.md
Name: length_counter_multi

Overview:
- Parametrised multi-channel length-counter bank for the APU: one independent length timer per sound channel, each gating its channel's enable.
- Clocked by the frame sequencer's length tick (256 Hz strobe).
- Supports 6-bit (pulse/noise) and 8-bit (wave) load widths.
- Implements the hardware quirks: reload-on-trigger-at-zero, extra clock on length-enable rising, and DAC-off kill.
- Sits between the register file (NRx1/NRx4 decode) and the channel mixers.

Parameters:
NUM_CH, 4, number of channels instantiated
LEN_W, 6, width of the length_load field per channel; counter max is 2**LEN_W

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
length_tick  input  1  one-cycle strobe from frame sequencer, steps that clock length
seq_phase_odd  input  1  high when the next frame-sequencer step does NOT clock length
length_load  input  NUM_CH*LEN_W  per-channel load value (channel c at [c*LEN_W +: LEN_W])
write_len  input  NUM_CH  one-cycle pulse: load counter from length_load
trigger  input  NUM_CH  one-cycle pulse: NRx4 trigger write
length_enable  input  NUM_CH  level: NRx4 bit 6
dac_en  input  NUM_CH  level: channel DAC powered
chan_enable  output  NUM_CH  channel active
counter_zero  output  NUM_CH  counter == 0 (status/debug)

Behaviour:
- Clock port is clk; reset is rst_n, asynchronous and active-low. Single clock domain.
- Per channel: counter of LEN_W+1 bits, chan_en flag, len_en_q (registered length_enable).
- Reset (async, rst_n=0): counter=0, chan_enable=0, len_en_q=0, counter_zero=1. Deassertion is synchronous to clk.
- All updates occur on posedge clk. Outputs are registered; latency is 1 cycle from any input event.
- write_len: counter <= 2**LEN_W - length_load. A load of 0 gives the max value (64 for LEN_W=6, 256 for LEN_W=8). Does not change chan_en.
- Length clock per channel ("clk_len"):
  - clk_len = (length_tick & length_enable) | extra_clk.
  - extra_clk = length_enable & ~len_en_q & seq_phase_odd, i.e. the rising edge of length_enable in the odd phase.
  - length_tick and extra_clk in the same cycle produce ONE decrement.
- On clk_len with counter != 0: counter decrements. If the result is 0 and trigger is not asserted, chan_en <= 0.
- clk_len with counter == 0: no change; no wrap-around.
- trigger:
  - chan_en <= dac_en.
  - If the post-decrement counter == 0, reload to 2**LEN_W. Reload to 2**LEN_W - 1 instead when length_enable=1 and seq_phase_odd=1.
  - A nonzero counter is kept.
- Priority within a cycle: write_len (counter value) > decrement > trigger reload. write_len together with trigger: load wins, and chan_en <= dac_en.
- dac_en=0 forces chan_en <= 0 next cycle, regardless of trigger.
- length_enable=0: counter frozen, chan_en unaffected by counting.
- counter_zero is registered, equal to (counter == 0).
- Channels are fully independent; no cross-channel interaction.

Decomposition:
- Shared package apu_pkg holds: LEN_W_SQ=6, LEN_W_WAVE=8, NUM_APU_CH=4, and the channel-index constants CH_SQ1, CH_SQ2, CH_WAVE, CH_NOISE.
- Sub-module length_counter_ch: single-channel counter plus flags, parametrised by LEN_W. The top level is a generate loop over NUM_CH plus port slicing.
- The wave channel is instantiated separately with LEN_W=8.

Test Plan:
- Reset then load: rst_n low then high; write_len ch0 with load=61, trigger=1, dac_en=1, length_enable=1; apply 3 length_ticks -> counter 3→2→1→0, chan_enable[0] falls the cycle after the 3rd tick, counter_zero[0]=1.
- Trigger at zero: counter=0, seq_phase_odd=0, trigger -> counter=64 and chan_enable=1. Repeat with seq_phase_odd=1 and length_enable=1 -> counter=63.
- Extra-clock quirk: counter=5, length_enable rises with seq_phase_odd=1 and no tick -> counter=4. Same with seq_phase_odd=0 -> stays 5. Rise coinciding with length_tick -> 4, not 3.
- DAC kill / disabled length: dac_en=0 with trigger -> chan_enable stays 0. length_enable=0 with 10 ticks -> counter unchanged.
- LEN_W=8 instance: load=0 -> counter=256; 256 ticks -> chan_enable falls exactly after the 256th tick, no wrap on the 257th.
- Async reset mid-count: rst_n pulled low between clk edges at counter=17 -> counter=0 and chan_enable=0 immediately, without a clock edge.
